// File: rtl/axis_xfft_config_rx_if.sv
// AXI-Stream bundle carrying the 16-bit xfft configuration word.
// The master drives data/valid/last; the slave returns ready.
interface axis_xfft_config_rx_if;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_xfft_config_rx.sv
// xfft config receiver: range-checks words, applies them at frame boundaries.
// Optional macro AXIS_CFG_TLAST_CHECK_EN also rejects words sent without tlast.
module axis_xfft_config_rx #(
  parameter int DEFAULT_NFFT    = 10,
  parameter int DEFAULT_FWD_INV = 1,
  parameter int NFFT_MIN        = 3,
  parameter int NFFT_MAX        = 16
) (
  input  logic                        aclk,
  input  logic                        resetn,
  axis_xfft_config_rx_if.slave        s_axis,
  input  logic                        mon_tvalid,
  input  logic                        mon_tready,
  input  logic                        mon_tlast,
  output logic [4:0]                  nfft_log2,
  output logic                        fwd_inv,
  output logic [5:0]                  scale_sch,
  output logic                        cfg_applied,
  output logic                        cfg_error,
  output logic                        frame_len_err,
  output logic [7:0]                  err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } state_t;

  localparam logic [4:0] MIN5 = 5'(NFFT_MIN);
  localparam logic [4:0] MAX5 = 5'(NFFT_MAX);

  state_t      state_q;
  state_t      state_d;
  logic        tready_q;
  logic [16:0] beat_cnt;
  logic [4:0]  sh_nfft;
  logic        sh_fwd;
  logic [5:0]  sh_scale;

  logic        accept;
  logic        mon_beat;
  logic        word_ok;
  logic        load_sh;
  logic        reject;
  logic [4:0]  eff_nfft;
  logic [16:0] frame_last;
  logic        at_end;
  logic        boundary;
  logic        unused_bits;

  assign s_axis.tready = tready_q;
  assign accept        = s_axis.tvalid & tready_q;
  assign mon_beat      = mon_tvalid & mon_tready;
  assign unused_bits   = ^{s_axis.tdata[9], s_axis.tdata[7:5], s_axis.tlast};

`ifdef AXIS_CFG_TLAST_CHECK_EN
  assign word_ok = (s_axis.tdata[4:0] >= MIN5) &&
                   (s_axis.tdata[4:0] <= MAX5) &&
                   s_axis.tlast;
`else
  assign word_ok = (s_axis.tdata[4:0] >= MIN5) &&
                   (s_axis.tdata[4:0] <= MAX5);
`endif

  // During APPLY the new size already governs the frame being counted
  assign eff_nfft   = (state_q == APPLY) ? sh_nfft : nfft_log2;
  assign frame_last = (17'd1 << eff_nfft) - 17'd1;
  assign at_end     = (beat_cnt == frame_last);
  assign boundary   = mon_beat & at_end;

  always_comb begin
    state_d = state_q;
    load_sh = 1'b0;
    reject  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (word_ok) begin
            load_sh = 1'b1;
            state_d = (beat_cnt == 17'd0 && !mon_beat) ? APPLY : PENDING;
          end else begin
            reject = 1'b1;
          end
        end
      end
      PENDING: begin
        if (boundary) state_d = APPLY;
      end
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      tready_q      <= 1'b0;
      nfft_log2     <= 5'(DEFAULT_NFFT);
      fwd_inv       <= 1'(DEFAULT_FWD_INV);
      scale_sch     <= 6'd0;
      cfg_applied   <= 1'b0;
      cfg_error     <= 1'b0;
      frame_len_err <= 1'b0;
      err_count     <= 8'd0;
      beat_cnt      <= 17'd0;
      sh_nfft       <= 5'd0;
      sh_fwd        <= 1'b0;
      sh_scale      <= 6'd0;
    end else begin
      state_q     <= state_d;
      tready_q    <= (state_d == IDLE);
      cfg_applied <= (state_q == APPLY);
      if (load_sh) begin
        sh_nfft  <= s_axis.tdata[4:0];
        sh_fwd   <= s_axis.tdata[8];
        sh_scale <= s_axis.tdata[15:10];
      end
      if (state_q == APPLY) begin
        nfft_log2 <= sh_nfft;
        fwd_inv   <= sh_fwd;
        scale_sch <= sh_scale;
      end
      if (reject) begin
        cfg_error <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
      if (mon_beat) begin
        beat_cnt <= at_end ? 17'd0 : beat_cnt + 17'd1;
        if (mon_tlast != at_end) frame_len_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_xfft_config_rx.sv
// Bench for axis_xfft_config_rx: scoreboard of applied configs plus
// direct checks of latency, range rejection and frame-length errors.
module tb_axis_xfft_config_rx;

  logic       aclk = 1'b0;
  logic       resetn = 1'b0;
  logic       mon_tvalid = 1'b0;
  logic       mon_tready = 1'b0;
  logic       mon_tlast = 1'b0;
  logic [4:0] nfft_log2;
  logic       fwd_inv;
  logic [5:0] scale_sch;
  logic       cfg_applied;
  logic       cfg_error;
  logic       frame_len_err;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;
  int exp_err = 0;
  logic [11:0] sb_q[$];

  axis_xfft_config_rx_if s_axis();

  axis_xfft_config_rx dut (
    .aclk          (aclk),
    .resetn        (resetn),
    .s_axis        (s_axis),
    .mon_tvalid    (mon_tvalid),
    .mon_tready    (mon_tready),
    .mon_tlast     (mon_tlast),
    .nfft_log2     (nfft_log2),
    .fwd_inv       (fwd_inv),
    .scale_sch     (scale_sch),
    .cfg_applied   (cfg_applied),
    .cfg_error     (cfg_error),
    .frame_len_err (frame_len_err),
    .err_count     (err_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each applied pulse must match the oldest queued word
  always @(negedge aclk) begin
    if (resetn && cfg_applied) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        chk("sb_cfg", {1'b0, scale_sch, fwd_inv, nfft_log2},
            {1'b0, sb_q.pop_front()});
      end
    end
  end

  function automatic logic [11:0] exp_of(input logic [15:0] w);
    return {w[15:10], w[8], w[4:0]};
  endfunction

  task automatic send_word(input logic [15:0] w, input logic last);
    int n = 0;
    while (s_axis.tready !== 1'b1 && n < 50) begin
      @(posedge aclk); #1; n++;
    end
    if (n >= 50) chk("tready_timeout", 0, 1);
    s_axis.tdata  = w;
    s_axis.tlast  = last;
    s_axis.tvalid = 1'b1;
    @(posedge aclk); #1;
    s_axis.tvalid = 1'b0;
  endtask

  task automatic send_bad(input logic [15:0] w, input logic last);
    send_word(w, last);
    if (exp_err < 255) exp_err++;
    chk("bad_tready", s_axis.tready, 1);
  endtask

  task automatic beat(input logic last);
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = last;
    @(posedge aclk); #1;
    mon_tvalid = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) beat(1'b0);
  endtask

  initial begin
    s_axis.tdata  = 16'h0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_nfft", nfft_log2, 10);
    chk("rst_fwd", fwd_inv, 1);
    chk("rst_scale", scale_sch, 0);
    chk("rst_tready", s_axis.tready, 0);
    chk("rst_err", {cfg_error, frame_len_err, cfg_applied}, 0);
    chk("rst_cnt", err_count, 0);
    resetn = 1'b1;
    @(posedge aclk); #1;
    chk("tready_up", s_axis.tready, 1);

    // idle stream: applied one edge after accept
    sb_q.push_back(exp_of(16'h0507));
    send_word(16'h0507, 1'b1);
    chk("idle_busy", s_axis.tready, 0);
    @(posedge aclk); #1;
    chk("idle_pulse", cfg_applied, 1);
    chk("idle_nfft", nfft_log2, 7);
    chk("idle_scale", scale_sch, 1);
    chk("idle_ready", s_axis.tready, 1);

    // mid-frame update with nfft=4
    sb_q.push_back(exp_of(16'h0104));
    send_word(16'h0104, 1'b1);
    @(posedge aclk); #1;
    beats(5);
    sb_q.push_back(exp_of(16'h0005));
    send_word(16'h0005, 1'b1);
    chk("pend_tready", s_axis.tready, 0);
    beats(10);
    chk("pend_hold", nfft_log2, 4);
    beat(1'b1);
    chk("bnd_hold", nfft_log2, 4);
    @(posedge aclk); #1;
    chk("mid_nfft", nfft_log2, 5);
    chk("mid_fwd", fwd_inv, 0);
    chk("mid_flen", frame_len_err, 0);

    // range check
    send_bad(16'h0002, 1'b1);
    send_bad(16'h0011, 1'b1);
    chk("rng_cnt", err_count, exp_err);
    chk("rng_err", cfg_error, 1);
    chk("rng_nfft", nfft_log2, 5);

`ifdef AXIS_CFG_TLAST_CHECK_EN
    send_bad(16'h0106, 1'b0);
    chk("tl_cnt", err_count, exp_err);
    chk("tl_nfft", nfft_log2, 5);
    sb_q.push_back(exp_of(16'h0106));
    send_word(16'h0106, 1'b1);
    @(posedge aclk); #1;
    chk("tl_apply", nfft_log2, 6);
`endif

    // frame length error with nfft=3
    sb_q.push_back(exp_of(16'h0103));
    send_word(16'h0103, 1'b1);
    @(posedge aclk); #1;
    beats(5);
    beat(1'b1);
    chk("flen_err", frame_len_err, 1);
    beat(1'b0);
    beat(1'b1);
    sb_q.push_back(exp_of(16'h0004));
    send_word(16'h0004, 1'b1);
    @(posedge aclk); #1;
    chk("wrap_apply", nfft_log2, 4);

    // word accepted on the boundary beat waits a full frame
    beats(15);
    sb_q.push_back(exp_of(16'h0006));
    s_axis.tdata  = 16'h0006;
    s_axis.tlast  = 1'b1;
    s_axis.tvalid = 1'b1;
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = 1'b1;
    @(posedge aclk); #1;
    s_axis.tvalid = 1'b0;
    mon_tvalid = 1'b0;
    mon_tlast  = 1'b0;
    chk("sim_tready", s_axis.tready, 0);
    @(posedge aclk); #1;
    chk("sim_hold", nfft_log2, 4);
    chk("sim_nopulse", cfg_applied, 0);
    beats(15);
    beat(1'b1);
    @(posedge aclk); #1;
    chk("sim_apply", nfft_log2, 6);

    // saturation
    for (int i = 0; i < 300; i++) send_bad(16'h0000, 1'b1);
    chk("sat_cnt", err_count, 255);
    chk("sat_model", err_count, exp_err);
    chk("sat_nfft", nfft_log2, 6);

    repeat (3) @(posedge aclk);
    chk("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_xfft_config_rx.md
Name: axis_xfft_config_rx

Overview:
- AXI-Stream slave that receives the 16-bit xfft configuration word, decodes and range-checks it, and drives the active transform settings to the datapath.
- A new configuration takes effect only at a frame boundary of a monitored data stream, so a frame never runs with mixed settings.
- Sits between the config master and the windowing/FFT datapath logic that consumes nfft_log2, fwd_inv and scale_sch.

Parameters:
- DEFAULT_NFFT, 10, reset value of nfft_log2.
- DEFAULT_FWD_INV, 1, reset value of fwd_inv (1 = forward).
- NFFT_MIN, 3, smallest accepted nfft_log2.
- NFFT_MAX, 16, largest accepted nfft_log2.

Ports:
- aclk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- s_axis_tdata  in  16  config word: [4:0] nfft_log2, [8] fwd_inv, [15:10] scale_sch; other bits ignored
- s_axis_tvalid  in  1  config word valid
- s_axis_tready  out  1  config word ready (registered)
- s_axis_tlast  in  1  config word last
- mon_tvalid  in  1  monitored data stream valid (snoop only)
- mon_tready  in  1  monitored data stream ready (snoop only)
- mon_tlast  in  1  monitored data stream last (snoop only)
- nfft_log2  out  5  active transform size, log2
- fwd_inv  out  1  active direction
- scale_sch  out  6  active scaling schedule
- cfg_applied  out  1  one-cycle pulse when new settings load
- cfg_error  out  1  sticky: a config word was rejected
- frame_len_err  out  1  sticky: mon_tlast disagrees with the beat count
- err_count  out  8  rejected-word count, saturates at 255

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state=IDLE; s_axis_tready=0.
  - nfft_log2=DEFAULT_NFFT, fwd_inv=DEFAULT_FWD_INV, scale_sch=0.
  - cfg_applied=0, cfg_error=0, frame_len_err=0, err_count=0, beat_cnt=0, shadow registers=0.
  - s_axis_tready rises at the first edge after reset release.
- Accept = s_axis_tvalid & s_axis_tready. Mon beat = mon_tvalid & mon_tready.
- frame_len = 1 << nfft_log2 (active value). beat_cnt is 17 bits.
  - Increments on each mon beat; wraps to 0 on the beat where beat_cnt == frame_len-1 (the boundary beat).
- FSM:
  - IDLE (tready=1). On accept, check NFFT_MIN <= tdata[4:0] <= NFFT_MAX.
    - Bad word: err_count += 1 (saturating), cfg_error <= 1, stay IDLE, tready stays 1.
    - Good word: latch fields into shadow, tready <= 0.
      - If beat_cnt==0 and no mon beat this cycle: go to APPLY.
      - Otherwise: go to PENDING.
  - PENDING (tready=0). On a boundary mon beat, go to APPLY. Otherwise hold.
  - APPLY (tready=0, one cycle). At the exiting edge: active outputs <= shadow, cfg_applied <= 1 for one cycle, tready <= 1, go to IDLE.
- Latency, idle stream: accept at edge E -> outputs and cfg_applied valid after edge E+1 -> tready high after E+1.
- Latency, mid-frame: outputs update one edge after the boundary beat's edge.
- frame_len switches at the APPLY edge. A mon beat during the APPLY cycle counts toward the new frame (beat_cnt 0 -> 1) and is compared against the new frame_len.
- Frame length check: set frame_len_err sticky if either:
  - mon_tlast=1 on a mon beat with beat_cnt != frame_len-1, or
  - mon_tlast=0 on the boundary beat.
  - beat_cnt keeps following its own count regardless; it does not resync to mon_tlast.
- Sticky flags and err_count clear only on reset. Reset mid-PENDING discards the shadow word.
- Simultaneous accept and boundary beat in IDLE: the word goes to PENDING and waits one full frame. It is not applied at that boundary.

Optional Feature:
- Macro: AXIS_CFG_TLAST_CHECK_EN.
- Defined: an accepted word with s_axis_tlast=0 is rejected like an out-of-range word (err_count++, cfg_error=1, no state change).
- Undefined: s_axis_tlast is ignored.

Test Plan:
- Reset, hold mon idle -> nfft_log2=10, fwd_inv=1, scale_sch=0, tready=1 one cycle after release. Send tdata=0x0507 -> nfft_log2=7, fwd_inv=1, scale_sch=1 and cfg_applied pulse one edge after accept.
- Mid-frame update: nfft=4 active, 5 mon beats sent, send 0x0005 -> tready=0, outputs unchanged until the 16th beat (tlast=1), then nfft_log2=5 and fwd_inv=0 one edge later.
- Range check: send nfft=2 then nfft=17 -> err_count=2, cfg_error=1, outputs unchanged, tready never drops.
- Frame length: nfft=3, assert mon_tlast on beat 6 -> frame_len_err=1. Beat count still wraps after beat 8.
- Saturation: 300 bad words -> err_count=255.
- Macro defined: valid nfft=6 with tlast=0 -> rejected, err_count++. Same word with tlast=1 -> applied.
